serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_link_pkg.sv | 40 ++++
 rtl/serial_tx_hold.sv | 37 +++
 rtl/serial_tx.sv | 179 +++++++++++++++++
 tb/tb_serial_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg -- constants and FSM encoding shared by the serial link
// transmitter and receiver.
//   DEFAULT_SIZE / DEFAULT_GAP : default word width and inter-frame idle cycles
//   START_LEN / PARITY_LEN     : fixed frame overhead in cycles
//   state_t                    : transmitter FSM encoding
//   frame_len()                : cycles from one start marker to the next when
//                                frames run back-to-back
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the even-parity bit).
package serial_link_pkg;

    localparam int DEFAULT_SIZE = 8;
    localparam int DEFAULT_GAP  = 1;
    localparam int START_LEN    = 1;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PARITY_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } state_t;
`else
    localparam int PARITY_LEN = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_GAP   = 3'd4
    } state_t;
`endif

    function automatic int frame_len(input int size, input int gap);
        return START_LEN + size + PARITY_LEN + gap;
    endfunction

endpackage

// File: rtl/serial_tx_hold.sv
// serial_tx_hold -- one-entry holding buffer in front of the transmitter.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset, empties the buffer
//   load_data : word captured when load is accepted
//   load      : load request; accepted only while the buffer is empty
//   drain     : buffer content has been taken by the shifter, mark empty
//   full      : buffer holds a word
//   data      : buffered word
module serial_tx_hold
    import serial_link_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [size-1:0] load_data,
    input  logic            load,
    input  logic            drain,
    output logic            full,
    output logic [size-1:0] data
);

    // Load is only honoured when empty and drain only happens when full,
    // so the two never collide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (load && !full) begin
            full <= 1'b1;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial frame transmitter.
// Frame: one start cycle (valid=1, data_out=1), size data bits LSB first,
// optional even-parity bit, then gap idle cycles before the next frame.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   tx_data  : parallel word to transmit
//   tx_load  : load request, accepted when tx_ready is high at a rising edge
//   tx_ready : holding buffer empty
//   valid    : frame-start marker, one cycle per frame
//   data_out : serial line
//   busy     : FSM not idle
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the PARITY state).
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | line low, waiting for a buffered word
// ST_START  | start marker: valid=1, data_out=1, one cycle
// ST_DATA   | size cycles, shift register LSB on the line
// ST_PARITY | one cycle, even parity of the data bits (macro only)
// ST_GAP    | gap cycles of forced idle between frames
module serial_tx
    import serial_link_pkg::*;
#(
    parameter int size = DEFAULT_SIZE,
    parameter int gap  = DEFAULT_GAP
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [size-1:0] tx_data,
    input  logic            tx_load,
    output logic            tx_ready,
    output logic            valid,
    output logic            data_out,
    output logic            busy
);

    localparam int         CNT_W    = $clog2(size);
    localparam logic [3:0] GAP_LOAD = (gap > 0) ? 4'(gap - 1) : 4'd0;

    state_t            state;
    state_t            state_next;
    state_t            after_frame;
    logic              buf_full;
    logic [size-1:0]   buf_data;
    logic              drain;
    logic [size-1:0]   shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              bit_last;
    logic [3:0]        gap_cnt;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_bit;
`endif

    serial_tx_hold #(
        .size (size)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .load_data (tx_data),
        .load      (tx_load),
        .drain     (drain),
        .full      (buf_full),
        .data      (buf_data)
    );

    assign tx_ready = ~buf_full;
    assign bit_last = (bit_cnt == CNT_W'(size - 1));

    // The buffer hands its word to the shifter on every entry into START,
    // which is what lets the next word be accepted during the frame.
    assign drain = (state_next == ST_START);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Where the frame goes once the last data/parity bit is out.
    always_comb begin
        if (gap > 0) begin
            after_frame = ST_GAP;
        end else if (buf_full) begin
            after_frame = ST_START;
        end else begin
            after_frame = ST_IDLE;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_last) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = after_frame;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                state_next = after_frame;
            end
`endif
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_next = buf_full ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        valid    = 1'b0;
        data_out = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_START: begin
                valid    = 1'b1;
                data_out = 1'b1;
            end
            ST_DATA: begin
                data_out = shift_reg[0];
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                data_out = parity_bit;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= 4'd0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (drain) begin
                shift_reg <= buf_data;
                bit_cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                parity_bit <= ^buf_data;
`endif
            end else if (state == ST_DATA) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_last ? '0 : bit_cnt + CNT_W'(1);
            end

            // Down-counter: loaded with gap-1 on entry, GAP exits at zero.
            if (state_next == ST_GAP && state != ST_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == ST_GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- scoreboard bench for serial_tx (size=8, gap=1).
// Stimulus pushes each accepted word into exp_q; an independent monitor
// deserialises every frame off the line and compares it with the queue head.
// Optional feature macro: SERIAL_TX_PARITY_EN (must match the RTL build).
module tb_serial_tx;
    import serial_link_pkg::*;

    localparam int SIZE = 8;
    localparam int GAP  = 1;
    localparam int PER  = frame_len(SIZE, GAP);

    logic            clock;
    logic            reset;
    logic [SIZE-1:0] tx_data;
    logic            tx_load;
    logic            tx_ready;
    logic            valid;
    logic            data_out;
    logic            busy;

    int              checks;
    int              errors;
    int              cyc;
    int              nvalid;
    logic [SIZE-1:0] exp_q[$];
    int              vt_q[$];

    serial_tx #(
        .size (SIZE),
        .gap  (GAP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .valid    (valid),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Presents a word; returns the posedge index at which it was accepted.
    task automatic load_word(input logic [SIZE-1:0] w, input int budget, output int acc);
        logic ok;
        ok = 1'b0;
        acc = -1;
        tx_data = w;
        tx_load = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (ok) begin
            exp_q.push_back(w);
            @(posedge clock);
            #1;
            acc = cyc;
        end else begin
            check("load_timeout", 32'd0, 32'd1);
        end
        tx_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && tx_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: one frame per valid pulse, aborted silently by reset.
    initial begin : monitor
        logic [SIZE-1:0] word;
        logic [SIZE-1:0] exp;
        logic            vlow;
        logic            aborted;
        logic            pbit;
        logic [1:0]      trail;
        pbit = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && valid) begin
                vt_q.push_back(cyc);
                nvalid++;
                check("start_bit", {31'd0, data_out}, 32'd1);
                word    = '0;
                vlow    = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < SIZE; b++) begin
                    @(negedge clock);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    word[b] = data_out;
                    if (valid) vlow = 1'b0;
                end
`ifdef SERIAL_TX_PARITY_EN
                if (!aborted) begin
                    @(negedge clock);
                    if (!reset) aborted = 1'b1;
                    pbit = data_out;
                    if (valid) vlow = 1'b0;
                end
`endif
                if (!aborted) begin
                    @(negedge clock);
                    if (!reset) aborted = 1'b1;
                    trail = {valid, data_out};
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, word}, 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("frame_word", {24'd0, word}, {24'd0, exp});
                        check("valid_one_cycle", {31'd0, vlow}, 32'd1);
`ifdef SERIAL_TX_PARITY_EN
                        check("parity_bit", {31'd0, pbit}, {31'd0, ^exp});
`endif
                        check("gap_line", {30'd0, trail}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc1;
        int acc2;
        int rel;
        int nv;
        logic [SIZE-1:0] w;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        nvalid  = 0;
        reset   = 1'b0;
        tx_load = 1'b0;
        tx_data = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);

        // 8'hA5 from IDLE, loaded at the very first edge after release
        @(negedge clock);
        reset = 1'b1;
        rel = cyc;
        load_word(8'hA5, 4, acc1);
        check("first_edge_accept", acc1, rel + 1);
        @(posedge clock);
        #1;
        check("latency_valid", {31'd0, valid}, 32'd1);
        check("latency_start_line", {31'd0, data_out}, 32'd1);
        @(posedge clock);
        #1;
        check("latency_bit0", {31'd0, data_out}, 32'd1);
        repeat (PER - 2) @(posedge clock);
        #1;
        check("busy_in_gap", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        check("busy_after_gap", {31'd0, busy}, 32'd0);
        wait_idle(50);

        // 8'h55 then 8'hAA back-to-back
        vt_q.delete();
        load_word(8'h55, 4, acc1);
        load_word(8'hAA, 20, acc2);
        check("second_accept_at_start", acc2 - acc1, 32'd2);
        wait_idle(60);
        check("b2b_frames", vt_q.size(), 32'd2);
        if (vt_q.size() == 2) check("b2b_period", vt_q[1] - vt_q[0], PER);

        // Loopback words
        load_word(8'h00, 4, acc1);
        load_word(8'hFF, 20, acc1);
        load_word(8'h3C, 20, acc1);
        wait_idle(80);

        // Reset during data bit 4 of 8'hF0 with 8'h99 buffered
        load_word(8'hF0, 4, acc1);
        load_word(8'h99, 20, acc2);
        check("f0_buffer_accept", acc2 - acc1, 32'd2);
        repeat (4) @(posedge clock);
        #1;
        check("f0_bit4_line", {31'd0, data_out}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_data_out", {31'd0, data_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        nv = nvalid;
        reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("no_valid_after_release", nvalid, nv);
        check("idle_after_release", {31'd0, busy}, 32'd0);
        load_word(8'h5A, 4, acc1);
        wait_idle(40);
        check("frame_after_release", nvalid, nv + 1);

`ifdef SERIAL_TX_PARITY_EN
        vt_q.delete();
        load_word(8'h07, 4, acc1);
        load_word(8'h03, 20, acc2);
        wait_idle(60);
        check("par_frames", vt_q.size(), 32'd2);
        if (vt_q.size() == 2) check("par_period", vt_q[1] - vt_q[0], 32'd11);
`endif

        // tx_load held high with changing data: accepted at edges 0, 2, 12
        for (int i = 0; i < 13; i++) begin
            w = 8'h30 + 8'(i);
            tx_data = w;
            tx_load = 1'b1;
            if (i == 0) exp_q.push_back(8'h30);
            if (i == 2) exp_q.push_back(8'h32);
            if (i == 12) exp_q.push_back(8'h3C);
            @(posedge clock);
            #1;
        end
        tx_load = 1'b0;
        tx_data = 8'hEE;
        wait_idle(80);
        check("all_frames_seen", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
